// File: rtl/aibnd_avmm2_pkg.sv
// aibnd_avmm2_pkg: shared states, frame constants, status type and parity helper for the AVMM2 responder
package aibnd_avmm2_pkg;
  typedef enum logic [3:0] {
    IDLE, RX_CMD, RX_ADDR, RX_DATA, RX_PAR, BUS_REQ, BUS_RD, TX_START, TX_STAT, TX_DATA, TX_PAR
  } state_t;
  localparam logic [1:0] RX_START     = 2'b11;
  localparam logic [3:0] TX_START_NIB = 4'hF;
  localparam logic [3:0] TX_IDLE_NIB  = 4'h0;
  typedef struct packed {
    logic perr;
    logic tmo;
    logic is_read;
  } status_t;
  function automatic logic par_upd(input logic acc, input logic [1:0] sym);
    return acc ^ sym[1] ^ sym[0];
  endfunction
endpackage

// File: rtl/aibnd_avmm2_txser.sv
// aibnd_avmm2_txser: registered nibble serializer driving the two TX pads
module aibnd_avmm2_txser import aibnd_avmm2_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [3:0]        nib_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [1:0]        idat0_o,
  output logic [1:0]        idat1_o,
  output logic              last_o
);
  localparam int NN = DATA_W / 4;
  localparam int CW = $clog2(NN + 1);
  logic [DATA_W-1:0] sh_q;
  logic [3:0]        nib_q;
  logic [CW-1:0]     cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      nib_q <= TX_IDLE_NIB;
      cnt_q <= '0;
    end else if (load_i) begin
      sh_q  <= data_i >> 4;
      nib_q <= data_i[3:0];
      cnt_q <= '0;
    end else if (shift_i) begin
      sh_q  <= sh_q >> 4;
      nib_q <= sh_q[3:0];
      cnt_q <= cnt_q + 1'b1;
    end else begin
      nib_q <= nib_i;
    end
  end
  assign last_o  = cnt_q == CW'(NN - 1);
  assign idat0_o = {nib_q[2], nib_q[0]};
  assign idat1_o = {nib_q[3], nib_q[1]};
endmodule

// File: rtl/aibnd_avmm2_rsp.sv
// aibnd_avmm2_rsp: AVMM2 responder; RX command frames -> single Avalon-MM access -> TX response frame
module aibnd_avmm2_rsp import aibnd_avmm2_pkg::*; #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              avmm_clk,
  input  logic              avmm_sync_rst,
  input  logic              avmm2_odat0,
  input  logic              avmm2_odat1,
  output logic [1:0]        avmm2_idat0,
  output logic [1:0]        avmm2_idat1,
  output logic              tx_active,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_write,
  output logic              m_read,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rdatavalid,
  output logic [7:0]        drop_cnt
);
  state_t            state_q, state_d;
  logic [15:0]       cnt_q;
  logic              is_wr_q, par_q, m_write_q, m_read_q, tx_active_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  status_t           stat_q;
  logic [7:0]        drop_q;
  logic [1:0]        sym;
  logic              tmo_hit, rd_cap, tmo_ev, tx_last, tx_load, tx_shift;
  logic [3:0]        tx_nib;
  assign sym     = {avmm2_odat1, avmm2_odat0};
  assign tmo_hit = cnt_q == 16'(TIMEOUT_CYC - 1);
  assign rd_cap  = m_rdatavalid && !is_wr_q && (state_q == BUS_RD || (state_q == BUS_REQ && !m_waitrequest));
  assign tmo_ev  = tmo_hit && (state_q == BUS_REQ ? m_waitrequest : state_q == BUS_RD && !m_rdatavalid);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = sym == RX_START ? RX_CMD : IDLE;
      RX_CMD:   state_d = RX_ADDR;
      RX_ADDR:  state_d = cnt_q == 16'(ADDR_W/2 - 1) ? (is_wr_q ? RX_DATA : RX_PAR) : RX_ADDR;
      RX_DATA:  state_d = cnt_q == 16'(DATA_W/2 - 1) ? RX_PAR : RX_DATA;
      RX_PAR:   state_d = avmm2_odat0 == par_q ? BUS_REQ : TX_START;
      BUS_REQ:  state_d = !m_waitrequest ? ((is_wr_q || m_rdatavalid) ? TX_START : BUS_RD)
                                         : (tmo_hit ? TX_START : BUS_REQ);
      BUS_RD:   state_d = (m_rdatavalid || tmo_hit) ? TX_START : BUS_RD;
      TX_START: state_d = TX_STAT;
      TX_STAT:  state_d = stat_q.is_read ? TX_DATA : TX_PAR;
      TX_DATA:  state_d = tx_last ? TX_PAR : TX_DATA;
      TX_PAR:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // Serializer commands describe the nibble that will be on the pads next cycle
  assign tx_load  = state_q == TX_STAT && state_d == TX_DATA;
  assign tx_shift = state_q == TX_DATA && state_d == TX_DATA;
  assign tx_nib   = state_d == TX_START ? TX_START_NIB :
                    state_d == TX_STAT  ? {1'b0, stat_q} :
                    state_d == TX_PAR   ? {3'b0, ^{stat_q, rdata_q}} : TX_IDLE_NIB;
  always_ff @(posedge avmm_clk) begin
    if (avmm_sync_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      par_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      stat_q      <= '0;
      m_write_q   <= 1'b0;
      m_read_q    <= 1'b0;
      tx_active_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q <= state_d;
      // The timeout keeps counting across BUS_REQ -> BUS_RD
      cnt_q   <= (state_d != state_q && !(state_q == BUS_REQ && state_d == BUS_RD)) ? '0 : cnt_q + 16'd1;
      if (state_q == IDLE && state_d == RX_CMD) begin
        rdata_q <= '0;
        stat_q  <= '0;
      end
      if (state_q == RX_CMD) begin
        is_wr_q        <= avmm2_odat0;
        par_q          <= par_upd(1'b0, sym);
        stat_q.is_read <= !avmm2_odat0;
      end
      if (state_q == RX_ADDR) begin
        addr_q <= ADDR_W'({sym, addr_q} >> 2);
        par_q  <= par_upd(par_q, sym);
      end
      if (state_q == RX_DATA) begin
        wdata_q <= DATA_W'({sym, wdata_q} >> 2);
        par_q   <= par_upd(par_q, sym);
      end
      if (state_q == RX_PAR && state_d == TX_START) stat_q.perr <= 1'b1;
      if (rd_cap) rdata_q <= m_rdata;
      if (tmo_ev) stat_q.tmo <= 1'b1;
      m_write_q   <= state_d == BUS_REQ && is_wr_q;
      m_read_q    <= state_d == BUS_REQ && !is_wr_q;
      tx_active_q <= state_d inside {TX_START, TX_STAT, TX_DATA, TX_PAR};
      if (sym == RX_START && state_q inside {BUS_REQ, BUS_RD, TX_START, TX_STAT, TX_DATA, TX_PAR} && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end
  aibnd_avmm2_txser #(.DATA_W(DATA_W)) u_txser (
    .clk     (avmm_clk),
    .rst     (avmm_sync_rst),
    .load_i  (tx_load),
    .shift_i (tx_shift),
    .nib_i   (tx_nib),
    .data_i  (rdata_q),
    .idat0_o (avmm2_idat0),
    .idat1_o (avmm2_idat1),
    .last_o  (tx_last)
  );
  assign tx_active = tx_active_q;
  assign m_addr    = addr_q;
  assign m_write   = m_write_q;
  assign m_read    = m_read_q;
  assign m_wdata   = wdata_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_aibnd_avmm2_rsp.sv
// tb_aibnd_avmm2_rsp: directed bench for the AVMM2 responder with hand-computed frames
module tb_aibnd_avmm2_rsp;
  logic        clk = 1'b0, rst = 1'b1, od0 = 1'b0, od1 = 1'b0, wreq = 1'b0, rdv = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  idat0, idat1;
  logic        tx_active, m_write, m_read;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata;
  logic [7:0]  drop_cnt;
  int          n_chk = 0, n_pass = 0, n_exp = 0;
  logic [3:0]  exp_nib [0:15];

  always #5 clk = ~clk;

  aibnd_avmm2_rsp #(.ADDR_W(10), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .avmm_clk      (clk),
    .avmm_sync_rst (rst),
    .avmm2_odat0   (od0),
    .avmm2_odat1   (od1),
    .avmm2_idat0   (idat0),
    .avmm2_idat1   (idat1),
    .tx_active     (tx_active),
    .m_addr        (m_addr),
    .m_write       (m_write),
    .m_read        (m_read),
    .m_wdata       (m_wdata),
    .m_waitrequest (wreq),
    .m_rdata       (rdata),
    .m_rdatavalid  (rdv),
    .drop_cnt      (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input logic [1:0] s);
    {od1, od0} = s;
    tick();
  endtask

  task automatic send_frame(input logic wr, input logic [9:0] a, input logic [31:0] d, input logic bad);
    logic p;
    p = wr ^ (^a) ^ (wr ? ^d : 1'b0);
    sym(2'b11);
    sym({1'b0, wr});
    for (int i = 0; i < 5; i++) sym(a[2*i +: 2]);
    if (wr) for (int i = 0; i < 16; i++) sym(d[2*i +: 2]);
    sym({1'b0, p ^ bad});
    {od1, od0} = 2'b00;
  endtask

  task automatic exp_frame(input logic [2:0] st, input logic rd, input logic [31:0] d, input logic p);
    exp_nib[0] = 4'hF;
    exp_nib[1] = {1'b0, st};
    n_exp = 2;
    if (rd) for (int i = 0; i < 8; i++) begin
      exp_nib[n_exp] = d[4*i +: 4];
      n_exp++;
    end
    exp_nib[n_exp] = {3'b000, p};
    n_exp++;
  endtask

  task automatic expect_tx(input string tag);
    int b;
    b = 0;
    while (!tx_active && b < 60) begin
      tick();
      b++;
    end
    chk({tag, "_txstart"}, tx_active, 1);
    for (int i = 0; i < n_exp; i++) begin
      chk($sformatf("%s_nib%0d", tag, i), {idat1[1], idat0[1], idat1[0], idat0[0]}, exp_nib[i]);
      tick();
    end
    chk({tag, "_txend"}, tx_active, 0);
    chk({tag, "_idlenib"}, {idat1, idat0}, 0);
  endtask

  task automatic quiet(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_active || m_write || m_read) seen++;
      tick();
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end by itself");
    $fatal(1);
  end

  initial begin
    int c;
    repeat (3) tick();
    chk("rst_txact", tx_active, 0);
    chk("rst_wr", m_write, 0);
    chk("rst_rd", m_read, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_idat", {idat1, idat0}, 0);
    chk("rst_addr", m_addr, 0);
    rst = 1'b0;
    tick();
    // write, accepted at once
    send_frame(1'b1, 10'h155, 32'hDEADBEEF, 1'b0);
    chk("wr_pulse", m_write, 1);
    chk("wr_rd", m_read, 0);
    chk("wr_addr", m_addr, 10'h155);
    chk("wr_data", m_wdata, 32'hDEADBEEF);
    tick();
    chk("wr_once", m_write, 0);
    exp_frame(3'b000, 1'b0, 32'h0, 1'b0);
    expect_tx("wr");
    // read with 3 wait cycles, data two cycles after accept
    wreq = 1'b1;
    send_frame(1'b0, 10'h2A0, 32'h0, 1'b0);
    chk("rd_req", m_read, 1);
    chk("rd_addr", m_addr, 10'h2A0);
    chk("rd_nowr", m_write, 0);
    repeat (3) tick();
    chk("rd_held", m_read, 1);
    wreq = 1'b0;
    tick();
    chk("rd_drop", m_read, 0);
    chk("rd_notx", tx_active, 0);
    tick();
    rdv = 1'b1;
    rdata = 32'h12345678;
    tick();
    rdv = 1'b0;
    rdata = '0;
    exp_frame(3'b001, 1'b1, 32'h12345678, 1'b0);
    expect_tx("rd");
    // write with corrupted parity
    send_frame(1'b1, 10'h0F0, 32'h0000FFFF, 1'b1);
    chk("perr_nowr", m_write, 0);
    exp_frame(3'b100, 1'b0, 32'h0, 1'b1);
    expect_tx("perr");
    // read timeout; a late rdatavalid must be ignored
    wreq = 1'b1;
    send_frame(1'b0, 10'h3FF, 32'h0, 1'b0);
    c = 0;
    while (m_read && c < 20) begin
      c++;
      tick();
    end
    chk("tmo_len", c, 8);
    rdv = 1'b1;
    rdata = 32'hFFFFFFFF;
    exp_frame(3'b011, 1'b1, 32'h0, 1'b0);
    expect_tx("tmo");
    rdv = 1'b0;
    rdata = '0;
    // start symbols while busy
    send_frame(1'b0, 10'h001, 32'h0, 1'b0);
    repeat (3) sym(2'b11);
    {od1, od0} = 2'b00;
    expect_tx("drop3");
    chk("drop3_cnt", drop_cnt, 3);
    for (int f = 0; f < 14; f++) begin
      send_frame(1'b0, 10'h001, 32'h0, 1'b0);
      repeat (19) sym(2'b11);
      {od1, od0} = 2'b00;
      tick();
      if (f == 12) chk("drop_250", drop_cnt, 250);
    end
    chk("drop_sat", drop_cnt, 255);
    chk("drop_idle", tx_active, 0);
    wreq = 1'b0;
    // reset in RX_DATA
    sym(2'b11);
    sym(2'b01);
    repeat (5) sym(2'b10);
    repeat (3) sym(2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrx_drop", drop_cnt, 0);
    chk("rstrx_addr", m_addr, 0);
    chk("rstrx_txact", tx_active, 0);
    quiet("rstrx_quiet");
    // reset in BUS_REQ with a stalled read
    wreq = 1'b1;
    send_frame(1'b0, 10'h111, 32'h0, 1'b0);
    chk("rstrq_req", m_read, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrq_rd", m_read, 0);
    wreq = 1'b0;
    quiet("rstrq_quiet");
    // reset in BUS_RD, then data arrives for the abandoned read
    send_frame(1'b0, 10'h044, 32'h0, 1'b0);
    chk("rstbr_req", m_read, 1);
    tick();
    chk("rstbr_acc", m_read, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rdv = 1'b1;
    rdata = 32'hDEADBEEF;
    tick();
    rdv = 1'b0;
    rdata = '0;
    quiet("rstbr_quiet");
    // clean read with data in the accept cycle
    send_frame(1'b0, 10'h2AA, 32'h0, 1'b0);
    chk("cln_req", m_read, 1);
    rdv = 1'b1;
    rdata = 32'hA5A50F0F;
    tick();
    rdv = 1'b0;
    rdata = '0;
    chk("cln_rd", m_read, 0);
    exp_frame(3'b001, 1'b1, 32'hA5A50F0F, 1'b1);
    expect_tx("cln");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
